// File: rtl/fifo_param_ctrl.sv
// Parametrised synchronous FIFO with programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow error and hysteretic pause output.
module fifo_param_ctrl #(
   parameter int DATA_WIDTH    = 6,
   parameter int ADDRESS_WIDTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_enable,
   input  logic                     rd_enable,
   input  logic [DATA_WIDTH-1:0]    data_in,
   input  logic [ADDRESS_WIDTH:0]   afull_thr,
   input  logic [ADDRESS_WIDTH:0]   aempty_thr,
   input  logic                     err_clear,
   output logic [DATA_WIDTH-1:0]    data_out,
   output logic                     valid_out,
   output logic [ADDRESS_WIDTH:0]   count,
   output logic                     full_fifo,
   output logic                     empty_fifo,
   output logic                     almost_full_fifo,
   output logic                     almost_empty_fifo,
   output logic                     error_fifo,
   output logic                     pause
);

   localparam int SIZE = 2 ** ADDRESS_WIDTH;
   localparam logic [ADDRESS_WIDTH:0] SIZE_C = (ADDRESS_WIDTH + 1)'(SIZE);

   logic [DATA_WIDTH-1:0]    mem [SIZE];
   logic [ADDRESS_WIDTH-1:0] wr_ptr;
   logic [ADDRESS_WIDTH-1:0] rd_ptr;
   logic                     wr_acc;
   logic                     rd_acc;
   logic                     overflow;
   logic                     underflow;

   assign full_fifo         = (count == SIZE_C);
   assign empty_fifo        = (count == '0);
   assign almost_full_fifo  = (count >= afull_thr);
   assign almost_empty_fifo = (count <= aempty_thr);

   // A full FIFO still accepts a write when a read frees a slot on the same edge.
   assign rd_acc    = rd_enable & ~empty_fifo;
   assign wr_acc    = wr_enable & (~full_fifo | rd_acc);
   assign overflow  = wr_enable & ~wr_acc;
   assign underflow = rd_enable & empty_fifo;

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         data_out  <= '0;
         valid_out <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_acc) begin
            rd_ptr    <= rd_ptr + 1'b1;
            data_out  <= mem[rd_ptr];
            valid_out <= 1'b1;
         end else begin
            data_out  <= '0;
            valid_out <= 1'b0;
         end
         if (wr_acc && !rd_acc) begin
            count <= count + 1'b1;
         end else if (rd_acc && !wr_acc) begin
            count <= count - 1'b1;
         end
      end
   end

   // Violation takes priority over a simultaneous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         error_fifo <= 1'b0;
      end else if (overflow || underflow) begin
         error_fifo <= 1'b1;
      end else if (err_clear) begin
         error_fifo <= 1'b0;
      end
   end

   // Set has priority when the thresholds overlap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pause <= 1'b0;
      end else if (count >= afull_thr) begin
         pause <= 1'b1;
      end else if (count <= aempty_thr) begin
         pause <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fifo_param_ctrl.sv
// Bench for fifo_param_ctrl: directed plan steps followed by random traffic,
// checked against a queue-based reference model.
module tb_fifo_param_ctrl;

   localparam int DW   = 6;
   localparam int AW   = 2;
   localparam int SIZE = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_enable;
   logic          rd_enable;
   logic [DW-1:0] data_in;
   logic [AW:0]   afull_thr;
   logic [AW:0]   aempty_thr;
   logic          err_clear;
   logic [DW-1:0] data_out;
   logic          valid_out;
   logic [AW:0]   count;
   logic          full_fifo;
   logic          empty_fifo;
   logic          almost_full_fifo;
   logic          almost_empty_fifo;
   logic          error_fifo;
   logic          pause;

   fifo_param_ctrl #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
      .clk              (clk),
      .reset            (reset),
      .wr_enable        (wr_enable),
      .rd_enable        (rd_enable),
      .data_in          (data_in),
      .afull_thr        (afull_thr),
      .aempty_thr       (aempty_thr),
      .err_clear        (err_clear),
      .data_out         (data_out),
      .valid_out        (valid_out),
      .count            (count),
      .full_fifo        (full_fifo),
      .empty_fifo       (empty_fifo),
      .almost_full_fifo (almost_full_fifo),
      .almost_empty_fifo(almost_empty_fifo),
      .error_fifo       (error_fifo),
      .pause            (pause)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   logic [DW-1:0] q [$];
   logic [DW-1:0] m_dout;
   logic          m_valid;
   logic          m_err;
   logic          m_pause;

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      n_total++;
      assert (o === e) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
   endtask

   function automatic logic [31:0] b2w(input bit b);
      return {31'd0, b};
   endfunction

   task automatic check_all(input string ph);
      int n;
      n = q.size();
      chk({ph, ":count"},  32'(count), 32'(n));
      chk({ph, ":full"},   b2w(full_fifo), b2w(n == SIZE));
      chk({ph, ":empty"},  b2w(empty_fifo), b2w(n == 0));
      chk({ph, ":afull"},  b2w(almost_full_fifo), b2w(n >= int'(afull_thr)));
      chk({ph, ":aempty"}, b2w(almost_empty_fifo), b2w(n <= int'(aempty_thr)));
      chk({ph, ":dout"},   32'(data_out), 32'(m_dout));
      chk({ph, ":valid"},  b2w(valid_out), b2w(m_valid));
      chk({ph, ":err"},    b2w(error_fifo), b2w(m_err));
      chk({ph, ":pause"},  b2w(pause), b2w(m_pause));
   endtask

   // Reference behaviour for one clock edge, using pre-edge occupancy.
   task automatic model_edge();
      int  n;
      bit  rd_ok, wr_ok;
      n     = q.size();
      rd_ok = rd_enable && (n != 0);
      wr_ok = wr_enable && ((n != SIZE) || rd_ok);
      if (n >= int'(afull_thr))       m_pause = 1'b1;
      else if (n <= int'(aempty_thr)) m_pause = 1'b0;
      if ((wr_enable && !wr_ok) || (rd_enable && n == 0)) m_err = 1'b1;
      else if (err_clear)                                 m_err = 1'b0;
      if (rd_ok) begin
         m_dout  = q.pop_front();
         m_valid = 1'b1;
      end else begin
         m_dout  = '0;
         m_valid = 1'b0;
      end
      if (wr_ok) q.push_back(data_in);
   endtask

   task automatic model_reset();
      q.delete();
      m_dout  = '0;
      m_valid = 1'b0;
      m_err   = 1'b0;
      m_pause = 1'b0;
   endtask

   task automatic step(input bit wr, input bit rd, input logic [DW-1:0] din, input bit clr,
                       input string ph);
      @(negedge clk);
      wr_enable = wr;
      rd_enable = rd;
      data_in   = din;
      err_clear = clr;
      @(posedge clk);
      model_edge();
      #1;
      check_all(ph);
   endtask

   logic [DW-1:0] rnd;

   initial begin
      reset      = 1'b1;
      wr_enable  = 1'b0;
      rd_enable  = 1'b0;
      data_in    = '0;
      err_clear  = 1'b0;
      afull_thr  = 3'd3;
      aempty_thr = 3'd1;
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk);
      reset = 1'b0;

      // Fill to full
      step(1, 0, 6'h11, 0, "t1w1");
      step(1, 0, 6'h22, 0, "t1w2");
      step(1, 0, 6'h33, 0, "t1w3");
      chk("t1_afull_at3", b2w(almost_full_fifo), 32'd1);
      step(1, 0, 6'h3F, 0, "t1w4");
      chk("t1_full", b2w(full_fifo), 32'd1);
      chk("t1_pause", b2w(pause), 32'd1);

      // Overflow, then drain
      step(1, 0, 6'h05, 0, "t2ovf");
      chk("t2_count", 32'(count), 32'd4);
      chk("t2_err", b2w(error_fifo), 32'd1);
      step(0, 1, 6'h00, 0, "t2r1");
      chk("t2_d1", 32'(data_out), 32'h11);
      step(0, 1, 6'h00, 0, "t2r2");
      chk("t2_d2", 32'(data_out), 32'h22);
      step(0, 1, 6'h00, 0, "t2r3");
      chk("t2_d3", 32'(data_out), 32'h33);
      step(0, 1, 6'h00, 0, "t2r4");
      chk("t2_d4", 32'(data_out), 32'h3F);
      chk("t2_v4", b2w(valid_out), 32'd1);
      chk("t2_empty", b2w(empty_fifo), 32'd1);

      // Underflow and error clear
      step(0, 1, 6'h00, 0, "t3und");
      chk("t3_valid", b2w(valid_out), 32'd0);
      step(0, 0, 6'h00, 1, "t3clr");
      chk("t3_err_clr", b2w(error_fifo), 32'd0);
      step(0, 1, 6'h00, 1, "t3und_clr");
      chk("t3_set_wins", b2w(error_fifo), 32'd1);
      step(0, 0, 6'h00, 1, "t3clr2");

      // Simultaneous read/write while full, with pointer wrap
      step(1, 0, 6'h01, 0, "t4f1");
      step(1, 0, 6'h02, 0, "t4f2");
      step(1, 0, 6'h03, 0, "t4f3");
      step(1, 0, 6'h04, 0, "t4f4");
      step(1, 1, 6'h2A, 0, "t4rw");
      chk("t4_oldest", 32'(data_out), 32'h01);
      chk("t4_count", 32'(count), 32'd4);
      chk("t4_noerr", b2w(error_fifo), 32'd0);
      for (int i = 0; i < 6; i++) begin
         rnd = 6'($urandom);
         step(1, 1, rnd, 0, "t4wrap");
      end
      for (int i = 0; i < 4; i++) step(0, 1, 6'h00, 0, "t4drain");

      // Pause hysteresis
      step(1, 0, 6'h0A, 0, "t5w1");
      step(1, 0, 6'h0B, 0, "t5w2");
      step(1, 0, 6'h0C, 0, "t5w3");
      step(0, 0, 6'h00, 0, "t5idle");
      chk("t5_pause_set", b2w(pause), 32'd1);
      step(0, 1, 6'h00, 0, "t5r1");
      step(0, 0, 6'h00, 0, "t5hold");
      chk("t5_pause_hold", b2w(pause), 32'd1);
      step(0, 1, 6'h00, 0, "t5r2");
      step(0, 0, 6'h00, 0, "t5rel");
      chk("t5_pause_clr", b2w(pause), 32'd0);

      // Thresholds act combinationally; afull_thr=0 forces pause
      @(negedge clk);
      afull_thr = 3'd0;
      #1;
      chk("thr_afull0", b2w(almost_full_fifo), 32'd1);
      step(0, 0, 6'h00, 0, "thr0");
      chk("thr_pause0", b2w(pause), 32'd1);
      afull_thr  = 3'd3;
      aempty_thr = 3'd1;

      // Asynchronous reset between edges
      step(1, 0, 6'h15, 0, "t6w1");
      step(1, 0, 6'h16, 0, "t6w2");
      @(negedge clk);
      wr_enable = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_all("t6rst");
      chk("t6_count0", 32'(count), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      step(1, 0, 6'h07, 0, "t6w");
      step(0, 1, 6'h00, 0, "t6r");
      chk("t6_dout", 32'(data_out), 32'h07);

      // Random traffic with occasional threshold changes
      for (int i = 0; i < 400; i++) begin
         if ((i % 16) == 0) begin
            afull_thr  = 3'($urandom_range(0, 7));
            aempty_thr = 3'($urandom_range(0, 7));
         end
         rnd = 6'($urandom);
         step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), rnd,
              ($urandom_range(0, 7) == 0), "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
